// File: rtl/width_upsizer_if.sv
// Handshake bundle for width_upsizer: narrow beat stream in, packed wide word out.
// The parity_out signal exists only when UPSIZE_PARITY_EN is defined.
interface width_upsizer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 2
);
  localparam int OUT_W = IN_W * RATIO;

  logic             valid_in;
  logic             ready_in;
  logic [IN_W-1:0]  data_in;
  logic             flush;
  logic             valid_out;
  logic             ready_out;
  logic [OUT_W-1:0] data_out;
  logic [RATIO-1:0] keep_out;
`ifdef UPSIZE_PARITY_EN
  logic [RATIO-1:0] parity_out;

  modport master (
    output valid_in, data_in, flush, ready_out,
    input  ready_in, valid_out, data_out, keep_out, parity_out
  );
  modport slave (
    input  valid_in, data_in, flush, ready_out,
    output ready_in, valid_out, data_out, keep_out, parity_out
  );
`else
  modport master (
    output valid_in, data_in, flush, ready_out,
    input  ready_in, valid_out, data_out, keep_out
  );
  modport slave (
    input  valid_in, data_in, flush, ready_out,
    output ready_in, valid_out, data_out, keep_out
  );
`endif
endinterface

// File: rtl/width_upsizer.sv
// Packs RATIO IN_W-bit beats into one word with valid/ready on both sides and flush support.
// Optional macro UPSIZE_PARITY_EN adds per-slice even parity registered alongside data_out.
module width_upsizer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst,
  width_upsizer_if.slave  bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = $clog2(RATIO);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(RATIO - 1);

  cnt_t             r_cnt;
  logic [OUT_W-1:0] r_asm_data;
  logic [RATIO-1:0] r_asm_keep;
  logic             r_flush_pend;
  logic             r_valid_out;
  logic [OUT_W-1:0] r_data_out;
  logic [RATIO-1:0] r_keep_out;

  logic             w_out_free;
  logic             w_ready_in;
  logic             w_accept;
  logic             w_full;
  logic             w_flush_now;
  int               w_slice;
  logic [OUT_W-1:0] w_beat_data;
  logic [RATIO-1:0] w_beat_keep;
  logic             w_load;
  cnt_t             w_cnt_nxt;
  logic [OUT_W-1:0] w_asm_data_nxt;
  logic [RATIO-1:0] w_asm_keep_nxt;
  logic             w_pend_nxt;

  // Only the final beat needs a free output slot; earlier beats park in the assembly register.
  assign w_out_free  = !r_valid_out || bus.ready_out;
  assign w_ready_in  = !r_flush_pend && !((r_cnt == LAST) && !w_out_free);
  assign w_accept    = bus.valid_in && w_ready_in;
  assign w_full      = w_accept && (r_cnt == LAST);
  assign w_flush_now = bus.flush && !r_flush_pend && ((r_cnt != '0) || w_accept);

  // Assembly contents as they would look with the current beat merged in.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_slice     = (MSB_FIRST != 0) ? (RATIO - 1 - int'(r_cnt)) : int'(r_cnt);
    w_beat_data = r_asm_data;
    w_beat_keep = r_asm_keep;
    for (int k = 0; k < RATIO; k++) begin
      if (w_accept && (k == w_slice)) begin
        w_beat_data[k*IN_W +: IN_W] = bus.data_in;
        w_beat_keep[k]              = 1'b1;
      end
    end
  end

  always_comb begin
    w_load         = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_asm_data_nxt = r_asm_data;
    w_asm_keep_nxt = r_asm_keep;
    w_pend_nxt     = r_flush_pend;
    if (r_flush_pend) begin
      if (w_out_free) begin
        w_load         = 1'b1;
        w_cnt_nxt      = '0;
        w_asm_data_nxt = '0;
        w_asm_keep_nxt = '0;
        w_pend_nxt     = 1'b0;
      end
    end else if (w_full || (w_flush_now && w_out_free)) begin
      w_load         = 1'b1;
      w_cnt_nxt      = '0;
      w_asm_data_nxt = '0;
      w_asm_keep_nxt = '0;
    end else begin
      if (w_accept) begin
        w_cnt_nxt      = r_cnt + cnt_t'(1);
        w_asm_data_nxt = w_beat_data;
        w_asm_keep_nxt = w_beat_keep;
      end
      if (w_flush_now) w_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_asm_data   <= '0;
      r_asm_keep   <= '0;
      r_flush_pend <= 1'b0;
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
      r_keep_out   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_cnt        <= w_cnt_nxt;
      r_asm_data   <= w_asm_data_nxt;
      r_asm_keep   <= w_asm_keep_nxt;
      r_flush_pend <= w_pend_nxt;
      if (w_load) begin
        r_valid_out <= 1'b1;
        r_data_out  <= w_beat_data;
        r_keep_out  <= w_beat_keep;
      end else if (bus.ready_out) begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign bus.ready_in  = w_ready_in;
  assign bus.valid_out = r_valid_out;
  assign bus.data_out  = r_data_out;
  assign bus.keep_out  = r_keep_out;

`ifdef UPSIZE_PARITY_EN
  logic [RATIO-1:0] r_parity;
  logic [RATIO-1:0] w_parity_nxt;

  always_comb begin
    w_parity_nxt = '0;
    for (int k = 0; k < RATIO; k++) begin
      w_parity_nxt[k] = w_beat_keep[k] & (^w_beat_data[k*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= '0;
    end else if (w_load) begin
      r_parity <= w_parity_nxt;
    end
  end

  assign bus.parity_out = r_parity;
`endif
endmodule

// File: tb/tb_width_upsizer.sv
// Drives three width_upsizer configurations from one shared random stream and
// compares each against a beat-list reference model.
module tb_width_upsizer;
  logic       clk;
  logic       rst;
  logic       vin;
  logic [7:0] din;
  logic       fl;
  logic       rout;

  int n_cmp = 0;
  int n_err = 0;

  // d0: RATIO=4 MSB_FIRST=1, d1: RATIO=4 MSB_FIRST=0, d2: RATIO=2 MSB_FIRST=1
  width_upsizer_if #(.IN_W(8), .RATIO(4)) if0 ();
  width_upsizer_if #(.IN_W(8), .RATIO(4)) if1 ();
  width_upsizer_if #(.IN_W(8), .RATIO(2)) if2 ();

  width_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_d0 (.clk(clk), .rst(rst), .bus(if0.slave));
  width_upsizer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
  width_upsizer #(.IN_W(8), .RATIO(2), .MSB_FIRST(1)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));

  assign if0.valid_in = vin;  assign if0.data_in = din;  assign if0.flush = fl;  assign if0.ready_out = rout;
  assign if1.valid_in = vin;  assign if1.data_in = din;  assign if1.flush = fl;  assign if1.ready_out = rout;
  assign if2.valid_in = vin;  assign if2.data_in = din;  assign if2.flush = fl;  assign if2.ready_out = rout;

  logic [31:0] act_rdy [3];
  logic [31:0] act_v   [3];
  logic [31:0] act_data[3];
  logic [31:0] act_keep[3];

  assign act_rdy[0]  = 32'(if0.ready_in);  assign act_v[0] = 32'(if0.valid_out);
  assign act_rdy[1]  = 32'(if1.ready_in);  assign act_v[1] = 32'(if1.valid_out);
  assign act_rdy[2]  = 32'(if2.ready_in);  assign act_v[2] = 32'(if2.valid_out);
  assign act_data[0] = 32'(if0.data_out);  assign act_keep[0] = 32'(if0.keep_out);
  assign act_data[1] = 32'(if1.data_out);  assign act_keep[1] = 32'(if1.keep_out);
  assign act_data[2] = 32'(if2.data_out);  assign act_keep[2] = 32'(if2.keep_out);

`ifdef UPSIZE_PARITY_EN
  logic [31:0] act_par[3];
  assign act_par[0] = 32'(if0.parity_out);
  assign act_par[1] = 32'(if1.parity_out);
  assign act_par[2] = 32'(if2.parity_out);
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: beats buffered for the current word, one output slot, a pending-flush bit.
  logic [7:0]  m_buf [3][4];
  int          m_n   [3];
  bit          m_pend[3];
  bit          m_v   [3];
  logic [31:0] m_data[3];
  logic [3:0]  m_keep[3];

  function automatic int ratio_of(int d);
    return (d == 2) ? 2 : 4;
  endfunction

  function automatic int msb_of(int d);
    return (d == 1) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_n[d] = 0; m_pend[d] = 0; m_v[d] = 0; m_data[d] = '0; m_keep[d] = '0;
    end
  endtask

  function automatic bit model_rdy(int d);
    bit free;
    free = !m_v[d] || rout;
    return !m_pend[d] && !((m_n[d] == ratio_of(d) - 1) && !free);
  endfunction

  task automatic model_step(input int d, input bit rdy);
    bit free, load;
    int s;
    free = !m_v[d] || rout;
    load = 0;
    if (m_pend[d]) begin
      if (free) begin load = 1; m_pend[d] = 0; end
    end else begin
      if (vin && rdy) begin m_buf[d][m_n[d]] = din; m_n[d]++; end
      if (m_n[d] == ratio_of(d)) load = 1;
      else if (fl && m_n[d] > 0) begin
        if (free) load = 1; else m_pend[d] = 1;
      end
    end
    if (load) begin
      m_data[d] = '0;
      m_keep[d] = '0;
      for (int j = 0; j < m_n[d]; j++) begin
        s = (msb_of(d) != 0) ? (ratio_of(d) - 1 - j) : j;
        m_data[d] = m_data[d] | (32'(m_buf[d][j]) << (s * 8));
        m_keep[d][s] = 1'b1;
      end
      m_v[d] = 1;
      m_n[d] = 0;
    end else if (rout) begin
      m_v[d] = 0;
    end
  endtask

`ifdef UPSIZE_PARITY_EN
  function automatic logic [31:0] exp_par(int d);
    logic [31:0] p;
    p = '0;
    for (int k = 0; k < ratio_of(d); k++) p[k] = m_keep[d][k] & (^m_data[d][k*8 +: 8]);
    return p;
  endfunction
`endif

  // One clock: drive at negedge, check ready_in, advance model at posedge, check outputs.
  task automatic cycle(input bit v, input logic [7:0] b, input bit f, input bit r);
    bit exp_rdy[3];
    @(negedge clk);
    vin = v; din = b; fl = f; rout = r;
    #1;
    for (int d = 0; d < 3; d++) begin
      exp_rdy[d] = model_rdy(d);
      check($sformatf("d%0d_ready_in", d), act_rdy[d], 32'(exp_rdy[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d, exp_rdy[d]);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_valid_out", d), act_v[d], 32'(m_v[d]));
      if (m_v[d]) begin
        check($sformatf("d%0d_data_out", d), act_data[d], m_data[d]);
        check($sformatf("d%0d_keep_out", d), act_keep[d], 32'(m_keep[d]));
`ifdef UPSIZE_PARITY_EN
        check($sformatf("d%0d_parity_out", d), act_par[d], exp_par(d));
`endif
      end
    end
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    vin = 0; fl = 0; rout = 0;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_rst_valid", d), act_v[d], 32'd0);
      check($sformatf("d%0d_rst_data", d), act_data[d], 32'd0);
      check($sformatf("d%0d_rst_keep", d), act_keep[d], 32'd0);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check($sformatf("d%0d_rdy_after_rst", d), act_rdy[d], 32'd1);
  endtask

  initial begin
    rst = 1'b1; vin = 0; din = '0; fl = 0; rout = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d_init_valid", d), act_v[d], 32'd0);
      check($sformatf("d%0d_init_rdy", d), act_rdy[d], 32'd1);
    end

    // Two-beat word, MSB first, visible for exactly one cycle.
    do_reset();
    cycle(1, 8'hA1, 0, 1);
    cycle(1, 8'hB2, 0, 1);
    check("tp1_valid", act_v[2], 32'd1);
    check("tp1_data", act_data[2], 32'h0000A1B2);
    check("tp1_keep", act_keep[2], 32'h3);
    cycle(0, 8'h00, 0, 1);
    check("tp1_drop", act_v[2], 32'd0);

    // LSB-first back-to-back stream.
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 8'(i), 0, 1);
      check("tp2_rdy", act_rdy[1], 32'd1);
      if (i == 4) check("tp2_word0", act_data[1], 32'h04030201);
      if (i == 8) check("tp2_word1", act_data[1], 32'h08070605);
    end

    // Flush of a two-beat partial word.
    do_reset();
    cycle(1, 8'h11, 0, 1);
    cycle(1, 8'h22, 0, 1);
    cycle(0, 8'h00, 1, 1);
    check("tp4_valid", act_v[0], 32'd1);
    check("tp4_data", act_data[0], 32'h11220000);
    check("tp4_keep", act_keep[0], 32'hC);

    // Flush with a beat while the output slot is stalled.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 8'(i), 0, 0);
    cycle(1, 8'h11, 0, 0);
    cycle(1, 8'h22, 0, 0);
    cycle(1, 8'h33, 1, 0);
    check("tp5_rdy_pend", act_rdy[0], 32'd0);
    check("tp5_held", act_data[0], 32'h01020304);
    cycle(0, 8'h00, 1, 0);
    check("tp5_rdy_pend2", act_rdy[0], 32'd0);
    cycle(0, 8'h00, 0, 1);
    check("tp5_valid", act_v[0], 32'd1);
    check("tp5_data", act_data[0], 32'h11223300);
    check("tp5_keep", act_keep[0], 32'hE);

    // Reset with three beats buffered and a word waiting, then a clean word.
    do_reset();
    for (int i = 1; i <= 7; i++) cycle(1, 8'(8'h40 + i), 0, 0);
    check("tp6_pre_valid", act_v[0], 32'd1);
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 8'(8'hC0 + i), 0, 1);
    check("tp6_clean", act_data[0], 32'hC1C2C3C4);
    check("tp6_keep", act_keep[0], 32'hF);

    // Random traffic with phases of heavy, light and no backpressure.
    for (int c = 0; c < 4000; c++) begin
      int thr;
      thr = ((c / 256) % 3 == 0) ? 2 : (((c / 256) % 3 == 1) ? 8 : 10);
      if ($urandom_range(0, 599) == 0) do_reset();
      else cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < thr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
